// File: rtl/mux_serializer_if.sv
// Word-in / bit-out handshake bundle for mux_serializer; slave is the serializer's view.
interface mux_serializer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mux_serializer.sv
// Parallel-to-serial stage: first bit one cycle after word accept, 1 bit/cycle, no gap between words.
// Stalled output holds data/last/index/word; a new word is taken only when idle or on the final bit handshake.
module mux_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  mux_serializer_if.slave   bus
);
  localparam int              IW       = $clog2(WIDTH);
  localparam logic [IW-1:0]   LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [IW-1:0]    index;
  logic [WIDTH-1:0] word;
  logic             armed;
  logic [IW-1:0]    sel;
  logic             out_fire;
  logic             in_fire;

  assign bus.out_valid = (state == SHIFT);
  assign bus.out_last  = bus.out_valid && (index == LAST_IDX);
  assign out_fire      = bus.out_valid && bus.out_ready;

  // armed keeps in_ready low until the first edge after reset release.
  assign bus.in_ready  = armed && ((state == IDLE) || (out_fire && bus.out_last));
  assign in_fire       = bus.in_valid && bus.in_ready;

  assign sel           = LSB_FIRST ? index : (LAST_IDX - index);
  assign bus.out_data  = bus.out_valid && word[sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      index <= '0;
      word  <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (in_fire) begin
        word  <= bus.in_data;
        index <= '0;
        state <= SHIFT;
      end else if (out_fire) begin
        if (bus.out_last) begin
          state <= IDLE;
        end else begin
          index <= index + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux_serializer.sv
// Scoreboard bench: MSB-first and LSB-first serializers driven in lockstep, checked against per-word bit lists.
module tb_mux_serializer;
  localparam int W = 8;

  typedef struct {
    logic d;
    logic l;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         rdy_rand = 1'b0;
  logic         rdy_force = 1'b1;

  int   n_vec = 0;
  int   n_fail = 0;
  int   run_len = 0;
  int   max_run = 0;
  exp_t sb_m[$];
  exp_t sb_l[$];

  mux_serializer_if #(.WIDTH(W)) if_m ();
  mux_serializer_if #(.WIDTH(W)) if_l ();

  assign if_m.in_valid  = in_valid;
  assign if_m.in_data   = in_data;
  assign if_m.out_ready = out_ready;
  assign if_l.in_valid  = in_valid;
  assign if_l.in_data   = in_data;
  assign if_l.out_ready = out_ready;

  mux_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst_n(rst_n), .bus(if_m));
  mux_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst_n(rst_n), .bus(if_l));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the word's bits in send order, last flag on the final one.
  task automatic push_exp(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      sb_m.push_back('{d: w[W-1-i], l: (i == W-1)});
      sb_l.push_back('{d: w[i],     l: (i == W-1)});
    end
  endtask

  task automatic send_word(input logic [W-1:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!if_m.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!if_m.in_ready) check("send_timeout", 32'd0, 32'd1);
    else push_exp(w);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((sb_m.size() != 0 || sb_l.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_m", sb_m.size(), 0);
    check("drain_l", sb_l.size(), 0);
    @(negedge clk);
    check("idle_valid", if_m.out_valid, 1'b0);
    check("idle_ready", if_m.in_ready, 1'b1);
  endtask

  task automatic wait_handshakes(input int k);
    int hs = 0;
    int n = 0;
    while (hs < k && n < 100) begin
      @(negedge clk);
      if (if_m.out_valid && if_m.out_ready) hs++;
      n++;
    end
    check("hs_timeout", hs, k);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      run_len = if_m.out_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if_m.out_valid) begin
      if (!if_m.out_ready) begin
        check("m_stall_inrdy", if_m.in_ready, 1'b0);
      end else if (sb_m.size() == 0) begin
        check("m_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_m.pop_front();
        check("m_data", if_m.out_data, e.d);
        check("m_last", if_m.out_last, e.l);
        check("m_inrdy", if_m.in_ready, e.l);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if_l.out_valid) begin
      if (!if_l.out_ready) begin
        check("l_stall_inrdy", if_l.in_ready, 1'b0);
      end else if (sb_l.size() == 0) begin
        check("l_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_l.pop_front();
        check("l_data", if_l.out_data, e.d);
        check("l_last", if_l.out_last, e.l);
        check("l_inrdy", if_l.in_ready, e.l);
      end
    end
  end

  initial begin
    #3;
    check("rst_valid", if_m.out_valid, 1'b0);
    check("rst_data", if_m.out_data, 1'b0);
    check("rst_last", if_m.out_last, 1'b0);
    check("rst_inrdy_m", if_m.in_ready, 1'b0);
    check("rst_inrdy_l", if_l.in_ready, 1'b0);
    #19 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_inrdy", if_m.in_ready, 1'b1);
    check("post_rst_valid", if_m.out_valid, 1'b0);

    // Single word, both bit orders.
    @(posedge clk); #1;
    send_word(8'hA5);
    wait_drain();

    // Back-to-back words with no bubble.
    @(posedge clk); #1;
    max_run = 0;
    send_word(8'hF0);
    send_word(8'h0F);
    wait_drain();
    check("b2b_contig", max_run, 16);

    // Output stall of three cycles after the second bit.
    @(posedge clk); #1;
    send_word(8'h3C);
    wait_handshakes(2);
    rdy_force = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", if_m.out_valid, 1'b1);
      check("stall_data_m", if_m.out_data, (sb_m.size() != 0) ? sb_m[0].d : 1'bx);
      check("stall_last_m", if_m.out_last, (sb_m.size() != 0) ? sb_m[0].l : 1'bx);
      check("stall_data_l", if_l.out_data, (sb_l.size() != 0) ? sb_l[0].d : 1'bx);
      check("stall_inrdy", if_m.in_ready, 1'b0);
    end
    rdy_force = 1'b1;
    wait_drain();

    // Reset in the middle of a word.
    @(posedge clk); #1;
    send_word(8'hFF);
    wait_handshakes(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb_m.delete();
    sb_l.delete();
    #1;
    check("mid_rst_valid_m", if_m.out_valid, 1'b0);
    check("mid_rst_valid_l", if_l.out_valid, 1'b0);
    check("mid_rst_data", if_m.out_data, 1'b0);
    check("mid_rst_last", if_m.out_last, 1'b0);
    check("mid_rst_inrdy", if_m.in_ready, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rel_inrdy", if_m.in_ready, 1'b1);
    check("rel_valid", if_m.out_valid, 1'b0);
    @(posedge clk); #1;
    send_word(8'h01);
    wait_drain();

    // in_data churns while a word is in flight.
    @(posedge clk); #1;
    send_word(8'h96);
    repeat (10) begin
      @(posedge clk);
      #1 in_data = W'($urandom);
    end
    wait_drain();

    // Random words, gaps and output backpressure.
    rdy_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      send_word(W'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mux_serializer.md
Name: mux_serializer

Overview:
- Parallel-to-serial stage that feeds the single-bit mux datapath.
- Accepts a WIDTH-bit word on a valid/ready handshake, stores it, and emits it one bit per output handshake.
- A bit-index counter drives the select of a WIDTH:1 mux over the stored word.
- Marks the final bit of each word and supports back-to-back words with no idle cycle.

Parameters:
- WIDTH, 8, bits per word; legal range 2..32.
- LSB_FIRST, 0, bit order: 0 sends bit WIDTH-1 first, 1 sends bit 0 first.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  parallel word; sampled only on in_valid && in_ready.
- out_valid  output  1  out_data holds a valid bit.
- out_ready  input  1  downstream consumes the bit this cycle.
- out_data  output  1  current serial bit, the mux output over the stored word.
- out_last  output  1  current bit is the last bit of its word.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset rst_n is asynchronous and active-low.
  - While rst_n=0: state=IDLE, index=0, stored word=0, out_valid=0, out_data=0, out_last=0, in_ready=0.
  - in_ready rises only after rst_n is released.
- State machine, two states:
  - IDLE: out_valid=0, in_ready=1. On in_valid=1, latch in_data, index=0, go to SHIFT.
  - SHIFT: out_valid=1.
    - On out_valid && out_ready && !out_last: index increments by 1 and the state stays SHIFT.
    - On out_valid && out_ready && out_last: go to IDLE, unless a new word is accepted in the same cycle; in that case latch it, index=0, stay in SHIFT.
- in_ready:
  - Equals (state==IDLE) || (out_valid && out_ready && out_last).
  - This is a combinational path from out_ready to in_ready; it is intended.
  - in_ready is never 1 in the middle of a word.
- Mux selection:
  - Mux select = index when LSB_FIRST=1, and WIDTH-1-index when LSB_FIRST=0.
  - out_data = stored_word[select], gated to 0 when out_valid=0.
- out_last = out_valid && (index == WIDTH-1).
- Counter:
  - Width is $clog2(WIDTH) bits.
  - Never exceeds WIDTH-1; no wrap occurs because the index reloads to 0 on each new word.
- Latency:
  - Word accepted at edge k; its first bit is valid in the cycle after edge k.
  - A word takes exactly WIDTH output handshakes.
  - With out_ready held at 1 and back-to-back input, throughput is 1 bit per cycle with no gap between words.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data, out_last, index and the stored word hold stable.
  - in_ready=0 in that condition, unless the state is IDLE.
- in_data is ignored while in_ready=0; changes there must not affect out_data.
- Reset mid-word: the partial word is discarded and out_valid drops to 0 immediately, without waiting for an edge. After release the block starts in IDLE.
- in_valid may be held with no handshake indefinitely; this has no side effects.

Test Plan:
- Reset then single word, WIDTH=8, LSB_FIRST=0, in_data=8'hA5, out_ready=1:
  - out_data sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - out_last=1 only on the 8th bit.
  - Then out_valid=0 and in_ready=1.
- Same word with LSB_FIRST=1 -> sequence 1,0,1,0,0,1,0,1 reversed order of bits, i.e. bits 0..7 of A5 = 1,0,1,0,0,1,0,1, checked against the bit index.
- Back-to-back words 8'hF0 then 8'h0F, in_valid held, out_ready=1:
  - in_ready pulses on the last bit of F0.
  - 16 contiguous valid bits: 1111000000001111.
  - No idle cycle between words.
- Backpressure on 8'h3C: drop out_ready for 3 cycles after the 2nd bit.
  - out_data and out_last are frozen and in_ready=0 during the stall.
  - The full sequence 00111100 completes afterwards.
- Reset asserted after the 4th bit of 8'hFF:
  - out_valid=0 asynchronously.
  - After release, sending 8'h01 yields 00000001 with no residue from FF.
- in_data toggled while in_ready=0 mid-word -> emitted bits match the originally latched word exactly.
